keypad_emulator: RTL and testbench

- Synthesizable model of the 4x4 matrix keypad: the responder end of the row-scan/column-sense interface that the keypad scanner drives.
- Accepts key-press commands over a valid/ready handshake and closes the matching switch for a programmed hold time, with LFSR-driven contact bounce on press and release.
- Drives the column lines exactly as a real keypad would for whatever row pattern the scanner applies.
- Used on-chip for self-test, and in benches in place of the physical keypad.

---
 rtl/keypad_pkg.sv | 44 ++++
 rtl/bounce_lfsr.sv | 33 +++
 rtl/keypad_emulator.sv | 154 +++++++++++++++
 tb/tb_keypad_emulator.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad emulator.
package keypad_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StBounceIn,
        StHold,
        StBounceOut,
        StGap
    } state_e;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } key_pos_t;

    // Feedback taps 16,14,13,11 of a right-shifting Fibonacci LFSR map onto bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // Physical position of each hex key on the matrix.
    function automatic key_pos_t key_pos(input logic [3:0] key);
        key_pos_t p;
        case (key)
            4'h1:    p = '{row: 2'd0, col: 2'd0};
            4'h2:    p = '{row: 2'd0, col: 2'd1};
            4'h3:    p = '{row: 2'd0, col: 2'd2};
            4'hA:    p = '{row: 2'd0, col: 2'd3};
            4'h4:    p = '{row: 2'd1, col: 2'd0};
            4'h5:    p = '{row: 2'd1, col: 2'd1};
            4'h6:    p = '{row: 2'd1, col: 2'd2};
            4'hB:    p = '{row: 2'd1, col: 2'd3};
            4'h7:    p = '{row: 2'd2, col: 2'd0};
            4'h8:    p = '{row: 2'd2, col: 2'd1};
            4'h9:    p = '{row: 2'd2, col: 2'd2};
            4'hC:    p = '{row: 2'd2, col: 2'd3};
            4'hE:    p = '{row: 2'd3, col: 2'd0};
            4'h0:    p = '{row: 2'd3, col: 2'd1};
            4'hF:    p = '{row: 2'd3, col: 2'd2};
            default: p = '{row: 2'd3, col: 2'd3}; // 4'hD
        endcase
        return p;
    endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// 16-bit Fibonacci LFSR supplying the contact chatter pattern.
module bounce_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic clk,
    input  logic reset,
    input  logic advance,
    output logic bit0
);
    import keypad_pkg::*;

    logic [15:0] lfsr_q, lfsr_d;

    // Shift right, feeding the tap parity into the top bit, only when asked to.
    always_comb begin
        lfsr_d = lfsr_q;
        if (advance) begin
            lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
        end
    end

    // LFSR register with synchronous reset to the seed.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bit0 = lfsr_q[0];

endmodule

// File: rtl/keypad_emulator.sv
// 4x4 matrix keypad responder: presses one key per command with bounce, hold and gap.
module keypad_emulator #(
    parameter int unsigned BOUNCE_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES   = 200,
    parameter int unsigned GAP_CYCLES    = 50,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       press_valid,
    input  logic [3:0] press_key,
    output logic       press_ready,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic       contact,
    output logic       busy
);
    import keypad_pkg::*;

    localparam int unsigned MAX_BH  = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_BH > GAP_CYCLES) ? MAX_BH : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

    typedef logic [CNT_W-1:0] cnt_t;

    // Counters hold "cycles remaining minus one"; terminal count is zero.
    localparam cnt_t LD_BOUNCE = cnt_t'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
    localparam cnt_t LD_HOLD   = cnt_t'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam cnt_t LD_GAP    = cnt_t'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic [3:0] key_q, key_d;
    logic       lfsr_adv;
    logic       lfsr_bit;
    key_pos_t   pos;

    bounce_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (lfsr_adv),
        .bit0    (lfsr_bit)
    );

    // State, counter and latched key registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
        end
    end

    // Next-state: walk bounce-in, hold, bounce-out, gap; zero-length phases are skipped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        unique case (state_q)
            StIdle: begin
                if (press_valid) begin
                    key_d = press_key;
                    if (BOUNCE_CYCLES != 0) begin
                        state_d = StBounceIn;
                        cnt_d   = LD_BOUNCE;
                    end else begin
                        state_d = StHold;
                        cnt_d   = LD_HOLD;
                    end
                end
            end
            StBounceIn: begin
                if (cnt_q == '0) begin
                    state_d = StHold;
                    cnt_d   = LD_HOLD;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    if (BOUNCE_CYCLES != 0) begin
                        state_d = StBounceOut;
                        cnt_d   = LD_BOUNCE;
                    end else if (GAP_CYCLES != 0) begin
                        state_d = StGap;
                        cnt_d   = LD_GAP;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            StBounceOut: begin
                if (cnt_q == '0) begin
                    if (GAP_CYCLES != 0) begin
                        state_d = StGap;
                        cnt_d   = LD_GAP;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            StGap: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: contact chatters from the LFSR in bounce states, with the last cycle forced.
    always_comb begin
        contact  = 1'b0;
        lfsr_adv = 1'b0;
        unique case (state_q)
            StBounceIn: begin
                lfsr_adv = 1'b1;
                contact  = (cnt_q == '0) ? 1'b1 : lfsr_bit;
            end
            StHold: contact = 1'b1;
            StBounceOut: begin
                lfsr_adv = 1'b1;
                contact  = (cnt_q == '0) ? 1'b0 : lfsr_bit;
            end
            default: contact = 1'b0;
        endcase
    end

    assign busy        = (state_q != StIdle);
    assign press_ready = (state_q == StIdle);

    // Closed switch pulls its column low only while its own row is driven low.
    always_comb begin
        cols = 4'hF;
        pos  = key_pos(key_q);
        if (contact && !rows[pos.row]) begin
            cols[pos.col] = 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: default-parameter DUT against a trace model,
// clean-edge DUT against a vector table and hand sequences.
module tb_keypad_emulator;

    localparam int          B    = 16;
    localparam int          H    = 200;
    localparam int          G    = 50;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          CH   = 10;
    localparam int          CG   = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter DUT
    logic       reset, press_valid, press_ready, contact, busy;
    logic [3:0] press_key, rows, cols;

    // Clean-edge DUT
    logic       c_reset, c_valid, c_ready, c_contact, c_busy;
    logic [3:0] c_key, c_rows, c_cols;

    keypad_emulator dut (
        .clk         (clk),
        .reset       (reset),
        .press_valid (press_valid),
        .press_key   (press_key),
        .press_ready (press_ready),
        .rows        (rows),
        .cols        (cols),
        .contact     (contact),
        .busy        (busy)
    );

    keypad_emulator #(
        .BOUNCE_CYCLES (0),
        .HOLD_CYCLES   (CH),
        .GAP_CYCLES    (CG),
        .LFSR_SEED     (SEED)
    ) dut_clean (
        .clk         (clk),
        .reset       (c_reset),
        .press_valid (c_valid),
        .press_key   (c_key),
        .press_ready (c_ready),
        .rows        (c_rows),
        .cols        (c_cols),
        .contact     (c_contact),
        .busy        (c_busy)
    );

    int checks = 0;
    int errors = 0;

    // Keypad layout as printed: kmap[row][col]
    logic [3:0] kmap [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                '{4'h4, 4'h5, 4'h6, 4'hB},
                                '{4'h7, 4'h8, 4'h9, 4'hC},
                                '{4'hE, 4'h0, 4'hF, 4'hD}};

    // Model state: remaining contact trace of the in-flight press, latched key, LFSR.
    bit          trace[$];
    logic [3:0]  key_m;
    logic [15:0] m_lfsr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_cols(input logic [3:0] key, input bit on,
                                            input logic [3:0] r);
        logic [3:0] res;
        res = 4'hF;
        for (int ri = 0; ri < 4; ri++)
            for (int ci = 0; ci < 4; ci++)
                if (on && kmap[ri][ci] == key && r[ri] == 1'b0) res[ci] = 1'b0;
        return res;
    endfunction

    function automatic logic [15:0] lstep(input logic [15:0] l);
        logic [15:0] fb;
        fb = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'd1;
        return (l >> 1) | (fb << 15);
    endfunction

    // Queue the full contact waveform of one press.
    task automatic accept_model(input logic [3:0] k);
        key_m = k;
        for (int i = 0; i < B; i++) begin
            trace.push_back((i == B - 1) ? 1'b1 : m_lfsr[0]);
            m_lfsr = lstep(m_lfsr);
        end
        for (int i = 0; i < H; i++) trace.push_back(1'b1);
        for (int i = 0; i < B; i++) begin
            trace.push_back((i == B - 1) ? 1'b0 : m_lfsr[0]);
            m_lfsr = lstep(m_lfsr);
        end
        for (int i = 0; i < G; i++) trace.push_back(1'b0);
    endtask

    // One clock of the default DUT: drive, compare against the model, advance both.
    task automatic tick(input logic rst, input logic v, input logic [3:0] k,
                        input logic [3:0] r, input bit do_chk);
        bit c;
        bit act;
        reset = rst; press_valid = v; press_key = k; rows = r;
        #1;
        act = (trace.size() > 0);
        c   = act ? trace[0] : 1'b0;
        if (do_chk) begin
            chk("contact", contact, c);
            chk("busy", busy, act);
            chk("press_ready", press_ready, !act);
            chk("cols", cols, exp_cols(key_m, c, r));
        end
        @(posedge clk);
        if (rst) begin
            trace.delete();
            m_lfsr = SEED;
        end else if (act) begin
            void'(trace.pop_front());
        end else if (v) begin
            accept_model(k);
        end
        #1;
    endtask

    task automatic c_step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] key;
        logic [3:0] rows;
        logic [3:0] cols;
    } vec_t;

    vec_t       tbl[11];
    logic [3:0] scan[4];
    int         ready_at, closed_cnt, hold_low, toggles, dut_acc;
    logic       prev_c3;

    initial begin
        tbl[0]  = '{4'h5, 4'b1101, 4'b1101};
        tbl[1]  = '{4'hA, 4'b1110, 4'b0111};
        tbl[2]  = '{4'h0, 4'b1110, 4'b1111};
        tbl[3]  = '{4'h0, 4'b0000, 4'b1101};
        tbl[4]  = '{4'hD, 4'b0111, 4'b0111};
        tbl[5]  = '{4'hE, 4'b0111, 4'b1110};
        tbl[6]  = '{4'h3, 4'b1011, 4'b1111};
        tbl[7]  = '{4'h9, 4'b1011, 4'b1011};
        tbl[8]  = '{4'h7, 4'b0000, 4'b1110};
        tbl[9]  = '{4'hB, 4'b1100, 4'b0111};
        tbl[10] = '{4'hC, 4'b1011, 4'b0111};
        scan[0] = 4'b1110; scan[1] = 4'b1101; scan[2] = 4'b1011; scan[3] = 4'b0111;

        m_lfsr = SEED; key_m = 4'h0;
        c_reset = 1'b1; c_valid = 1'b0; c_key = 4'h0; c_rows = 4'b1110;
        tick(1'b1, 1'b0, 4'h0, 4'b1110, 1'b0);
        tick(1'b1, 1'b0, 4'h0, 4'b1110, 1'b0);
        c_reset = 1'b0;

        // Reset state of both instances
        chk("rst_cols", cols, 4'hF);
        chk("rst_ready", press_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_contact", contact, 1'b0);
        chk("c_rst_cols", c_cols, 4'hF);
        chk("c_rst_ready", c_ready, 1'b1);
        tick(1'b0, 1'b0, 4'h0, 4'b1110, 1'b1);

        // Column map during HOLD, then reset aborts the press
        for (int i = 0; i < 11; i++) begin
            c_key = tbl[i].key; c_valid = 1'b1; c_rows = 4'hF;
            c_step();
            c_valid = 1'b0; c_rows = tbl[i].rows;
            #1;
            chk("tbl_contact", c_contact, 1'b1);
            chk("tbl_cols", c_cols, tbl[i].cols);
            c_reset = 1'b1;
            c_step();
            c_reset = 1'b0;
            chk("tbl_rst_cols", c_cols, 4'hF);
            chk("tbl_rst_ready", c_ready, 1'b1);
        end

        // Clean press of key 5 under a rotating row scan
        c_key = 4'h5; c_valid = 1'b1; c_rows = 4'hF;
        c_step();
        c_valid = 1'b0; c_key = 4'h9;
        ready_at = -1; closed_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            c_rows = scan[i % 4];
            #1;
            chk("scan_cols", c_cols,
                (i < CH && c_rows == 4'b1101) ? 4'b1101 : 4'b1111);
            if (c_contact) closed_cnt++;
            if (c_ready && ready_at < 0) ready_at = i;
            c_step();
        end
        chk("scan_hold_len", closed_cnt, CH);
        chk("scan_ready_return", ready_at, CH + CG);

        // Bounced press of key D with its row held low
        tick(1'b0, 1'b1, 4'hD, 4'b0111, 1'b1);
        hold_low = 0; toggles = 0; prev_c3 = cols[3];
        for (int j = 0; j < 2 * B + H + G + 2; j++) begin
            if (j > 0 && j < B && cols[3] != prev_c3) toggles++;
            if (j >= B && j < B + H && cols[3] == 1'b0) hold_low++;
            if (j == 2 * B + H - 1) chk("bounce_out_end", cols[3], 1'b1);
            prev_c3 = cols[3];
            tick(1'b0, 1'b0, 4'hD, 4'b0111, 1'b1);
        end
        chk("bounce_toggled", (toggles > 0), 1'b1);
        chk("hold_low_cycles", hold_low, H);

        // Back-pressure: valid held high, exactly three presses
        dut_acc = 0;
        for (int n = 0; n < 3 * (2 * B + H + G + 1); n++) begin
            if (press_ready) dut_acc++;
            tick(1'b0, 1'b1, 4'h1, 4'b1110, 1'b1);
        end
        chk("backpressure_accepts", dut_acc, 3);

        // Reset in the middle of HOLD on key A
        tick(1'b0, 1'b1, 4'hA, 4'b1110, 1'b1);
        for (int n = 0; n < B + 30; n++) tick(1'b0, 1'b0, 4'h2, 4'b1110, 1'b1);
        chk("midhold_cols", cols, 4'b0111);
        tick(1'b1, 1'b0, 4'h0, 4'b1110, 1'b1);
        chk("midhold_rst_cols", cols, 4'hF);
        chk("midhold_rst_ready", press_ready, 1'b1);
        tick(1'b0, 1'b0, 4'h0, 4'b1110, 1'b1);

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            tick(($urandom_range(0, 599) == 0), ($urandom_range(0, 3) == 0),
                 4'($urandom), 4'($urandom), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
